// File: rtl/jk_seq_pkg.sv
// Shared definitions for the JK sequencing controller: opcodes, per-bit
// J/K drive codes, FSM state encoding and small opcode classifiers.
package jk_seq_pkg;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_LOAD   = 3'd2;
    localparam logic [2:0] OP_TOGGLE = 3'd3;
    localparam logic [2:0] OP_UP     = 3'd4;
    localparam logic [2:0] OP_DOWN   = 3'd5;

    // {J, K} drive pairs for a single cell
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Multi-cycle counting opcodes take their length from cmd_steps
    function automatic logic is_count_op(input logic [2:0] op);
        return (op == OP_UP) || (op == OP_DOWN);
    endfunction

    // Opcodes 6 and 7 are reserved and flag err on completion
    function automatic logic is_reserved_op(input logic [2:0] op);
        return op > OP_DOWN;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-low reset.
module jk_cell
    import jk_seq_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;
    logic q_d;

    // JK truth table: hold, clear, set, toggle
    always_comb begin
        case ({j, k})
            JK_HOLD: q_d = q_q;
            JK_CLR:  q_d = 1'b0;
            JK_SET:  q_d = 1'b1;
            default: q_d = ~q_q;
        endcase
    end

    // Cell state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_seq_ctrl.sv
// Command-driven sequencer for a bank of JK cells. Accepts one command in
// IDLE, drives one J/K pattern per EXEC cycle, then reports in DONE.
module jk_seq_ctrl
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_steps,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             err
);

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               wrap_q, wrap_d;
    logic               err_q, err_d;

    logic               accept;
    logic               exec;
    logic               last_step;
    logic [WIDTH-1:0]   bank_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    if (last_step) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output decode; ready/busy come straight from state, not from cmd_*
    always_comb begin
        cmd_ready = (state_q == IDLE);
        busy      = (state_q == EXEC) || (state_q == DONE);
        exec      = (state_q == EXEC);
        accept    = cmd_valid && (state_q == IDLE);
        last_step = (state_q == EXEC) && (cnt_q <= CNT_W'(1));
    end

    // Command latch and step counter; zero steps is stretched to one
    always_comb begin
        op_d   = op_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        if (accept) begin
            op_d   = cmd_op;
            data_d = cmd_data;
            if (is_count_op(cmd_op) && (cmd_steps != '0)) begin
                cnt_d = cmd_steps;
            end else begin
                cnt_d = CNT_W'(1);
            end
        end else if (exec) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Status pulses are registered so they line up with the updated q
    always_comb begin
        done_d = last_step;
        err_d  = last_step && is_reserved_op(op_q);
        wrap_d = exec && (((op_q == OP_UP) && (&bank_q)) ||
                          ((op_q == OP_DOWN) && (bank_q == '0)));
    end

    // Command latch, counter and status registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_q   <= '0;
            data_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            op_q   <= op_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic       below_ones;
            logic       below_zeros;
            logic [1:0] drv;

            // Counting carries: bit 0 always toggles, higher bits look at all lower bits
            if (gi == 0) begin : g_lsb
                assign below_ones  = 1'b1;
                assign below_zeros = 1'b1;
            end else begin : g_upper
                assign below_ones  = &bank_q[gi-1:0];
                assign below_zeros = ~|bank_q[gi-1:0];
            end

            // Per-bit J/K drive; everything holds outside EXEC
            always_comb begin
                drv = JK_HOLD;
                if (exec) begin
                    case (op_q)
                        OP_CLEAR:  drv = JK_CLR;
                        OP_LOAD:   drv = data_q[gi] ? JK_SET : JK_CLR;
                        OP_TOGGLE: drv = data_q[gi] ? JK_TGL : JK_HOLD;
                        OP_UP:     drv = below_ones ? JK_TGL : JK_HOLD;
                        OP_DOWN:   drv = below_zeros ? JK_TGL : JK_HOLD;
                        default:   drv = JK_HOLD;
                    endcase
                end
            end

            jk_cell u_cell (
                .clk     (clk),
                .reset_n (reset_n),
                .j       (drv[1]),
                .k       (drv[0]),
                .q       (bank_q[gi])
            );
        end
    endgenerate

    assign q    = bank_q;
    assign done = done_q;
    assign wrap = wrap_q;
    assign err  = err_q;

endmodule
